// File: rtl/crc40_rx_feeder.sv
// Receive-side byte packer for the 40-bit CRC32 engine: builds 5-byte words, chains the
// engine output as the next seed, finishes tail bytes bit-serially and reports once per frame.
module crc40_rx_feeder #(
   parameter logic [31:0] RESIDUE = 32'hC704DD7B,
   parameter int unsigned LEN_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   input  logic             in_sop,
   input  logic             in_eop,
   output logic             in_ready,
   output logic [39:0]      crc_data,
   output logic [31:0]      crc_seed,
   output logic             crc_en,
   input  logic [31:0]      crc_value,
   output logic             res_valid,
   output logic [31:0]      res_crc,
   output logic             res_ok,
   output logic [LEN_W-1:0] res_len
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_GATHER = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_TLOAD  = 3'd3;
   localparam logic [2:0] S_TAIL   = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;
   localparam logic [31:0] POLY    = 32'h04C11DB7;

   logic [2:0]       state_q, state_d;
   logic [2:0]       idx_q, idx_d;
   logic [2:0]       last_idx_q, last_idx_d;
   logic             first_q, first_d;
   logic [39:0]      word_q, word_d;
   logic [39:0]      crc_data_q, crc_data_d;
   logic [31:0]      crc_seed_q, crc_seed_d;
   logic             crc_en_q, crc_en_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [5:0]       bit_q, bit_d;
   logic [31:0]      sreg_q, sreg_d;
   logic [31:0]      res_crc_q, res_crc_d;
   logic             res_ok_q, res_ok_d;
   logic             fin_word_q, fin_word_d;
   logic             accept;
   logic             fb;

   assign in_ready  = (state_q == S_IDLE) || (state_q == S_GATHER);
   assign accept    = in_valid & in_ready;
   assign crc_data  = crc_data_q;
   assign crc_seed  = crc_seed_q;
   assign crc_en    = crc_en_q;
   assign res_len   = len_q;
   assign res_valid = (state_q == S_DONE);
   // A frame ending on a word boundary reports the engine output directly: it only
   // becomes valid in the DONE cycle itself.
   assign res_crc   = (res_valid && fin_word_q) ? crc_value : res_crc_q;
   assign res_ok    = (res_valid && fin_word_q) ? (crc_value == RESIDUE) : res_ok_q;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      last_idx_d = last_idx_q;
      first_d    = first_q;
      word_d     = word_q;
      crc_data_d = crc_data_q;
      crc_seed_d = crc_seed_q;
      crc_en_d   = 1'b0;
      len_d      = len_q;
      bit_d      = bit_q;
      sreg_d     = sreg_q;
      res_crc_d  = res_crc_q;
      res_ok_d   = res_ok_q;
      fin_word_d = fin_word_q;
      fb         = 1'b0;
      case (state_q)
         S_IDLE, S_GATHER: begin
            if (accept && in_sop) begin
               // SOP always restarts, aborting any frame in progress without a result.
               word_d[7:0] = in_data;
               idx_d       = 3'd1;
               last_idx_d  = 3'd0;
               first_d     = 1'b1;
               len_d       = {{(LEN_W-1){1'b0}}, 1'b1};
               state_d     = in_eop ? S_TLOAD : S_GATHER;
            end else if (accept && (state_q == S_GATHER)) begin
               word_d[{idx_q, 3'b000} +: 8] = in_data;
               last_idx_d = idx_q;
               if (!(&len_q)) len_d = len_q + 1'b1;
               if (idx_q == 3'd4) begin
                  crc_data_d = {in_data, word_q[31:0]};
                  crc_seed_d = first_q ? 32'hFFFFFFFF : crc_value;
                  crc_en_d   = 1'b1;
                  first_d    = 1'b0;
                  idx_d      = 3'd0;
                  if (in_eop) state_d = S_WAIT;
               end else begin
                  idx_d = idx_q + 3'd1;
                  if (in_eop) state_d = S_TLOAD;
               end
            end
         end
         S_WAIT: begin
            fin_word_d = 1'b1;
            state_d    = S_DONE;
         end
         S_TLOAD: begin
            sreg_d  = first_q ? 32'hFFFFFFFF : crc_value;
            bit_d   = 6'd0;
            state_d = S_TAIL;
         end
         S_TAIL: begin
            // One bit of the engine's word update: earliest byte first, LSB first.
            fb     = sreg_q[31] ^ word_q[bit_q];
            sreg_d = {sreg_q[30:0], 1'b0} ^ ({32{fb}} & POLY);
            bit_d  = bit_q + 6'd1;
            if (bit_q == {last_idx_q, 3'b111}) begin
               res_crc_d = sreg_d;
               res_ok_d  = (sreg_d == RESIDUE);
               state_d   = S_DONE;
            end
         end
         S_DONE: begin
            res_crc_d  = res_crc;
            res_ok_d   = res_ok;
            fin_word_d = 1'b0;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         idx_q      <= 3'd0;
         last_idx_q <= 3'd0;
         first_q    <= 1'b1;
         word_q     <= '0;
         crc_data_q <= '0;
         crc_seed_q <= '0;
         crc_en_q   <= 1'b0;
         len_q      <= '0;
         bit_q      <= '0;
         sreg_q     <= '0;
         res_crc_q  <= '0;
         res_ok_q   <= 1'b0;
         fin_word_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         last_idx_q <= last_idx_d;
         first_q    <= first_d;
         word_q     <= word_d;
         crc_data_q <= crc_data_d;
         crc_seed_q <= crc_seed_d;
         crc_en_q   <= crc_en_d;
         len_q      <= len_d;
         bit_q      <= bit_d;
         sreg_q     <= sreg_d;
         res_crc_q  <= res_crc_d;
         res_ok_q   <= res_ok_d;
         fin_word_q <= fin_word_d;
      end
   end

endmodule
